// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the time-multiplexed wide carry-lookahead adder.
//   state_e      : sequencer states (IDLE / RUN / DONE)
//   DEF_WIDTH    : default operand width
//   DEF_SLICE    : default width of the shared CLA slice
//   nslice()     : number of slices needed for a given width
//   idx_width()  : bit width of the slice index counter
// ---------------------------------------------------------------------------
package cla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  // Slice count; WIDTH is required to be an integer multiple of SLICE.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Index register width; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/cla_wide_add_seq_slice.sv
// ---------------------------------------------------------------------------
// cla_slice_add
// Combinational SLICE-bit adder built from chained 4-bit carry-lookahead
// groups. Inside each group every carry is computed in two-level lookahead
// form from the group's generate/propagate terms; the group carry-out is
// formed from the group generate/propagate and feeds the next group.
// Ports:
//   a, b   : SLICE-bit addends
//   cin    : carry into bit 0
//   s      : SLICE-bit sum
//   cout   : carry out of bit SLICE-1
//   c_msb  : carry into bit SLICE-1 (used for signed overflow detection)
// ---------------------------------------------------------------------------
module cla_slice_add #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  localparam int NGRP = SLICE / 4;

  logic [3:0] gg;
  logic [3:0] pp;
  logic [4:0] cc;
  logic       grp_g;
  logic       grp_p;
  logic       carry_v;

  // Group-by-group lookahead; carry_v walks the inter-group chain.
  always_comb begin
    gg      = 4'b0000;
    pp      = 4'b0000;
    cc      = 5'b00000;
    grp_g   = 1'b0;
    grp_p   = 1'b0;
    carry_v = cin;
    s       = '0;
    c_msb   = 1'b0;
    for (int gi = 0; gi < NGRP; gi++) begin
      gg    = a[gi*4 +: 4] & b[gi*4 +: 4];
      pp    = a[gi*4 +: 4] ^ b[gi*4 +: 4];
      cc[0] = carry_v;
      cc[1] = gg[0] | (pp[0] & cc[0]);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & cc[0]);
      grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
      grp_p = &pp;
      cc[4] = grp_g | (grp_p & cc[0]);
      s[gi*4 +: 4] = pp ^ cc[3:0];
      if (gi == NGRP - 1) begin
        c_msb = cc[3];
      end else begin
        c_msb = c_msb;
      end
      carry_v = cc[4];
    end
    cout = carry_v;
  end

endmodule

// File: rtl/cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// cla_wide_add_seq
// WIDTH-bit add/subtract performed over NSLICE clocks by one shared SLICE-bit
// carry-lookahead slice, least significant slice first, with the carry
// registered between slices.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   op_a, op_b, sub     : operands; sub = 1 computes A - B
//   out_valid/out_ready : result handshake (result held in DONE)
//   sum, carry_out      : result and carry out of the MSB (sub: 1 = no borrow)
//   overflow            : two's-complement signed overflow
//   op_count            : completed-operation counter, present only when
//                         CLA_WIDE_ADD_STATS_EN is defined
// ---------------------------------------------------------------------------
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
`ifdef CLA_WIDE_ADD_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               last_s;
  logic [SLICE-1:0]   slice_sum_s;
  logic               slice_cout_s;
  logic               slice_cmsb_s;

  // The operand registers are shifted right by SLICE every RUN cycle, so the
  // active slice always sits in the low bits; no variable part-select needed.
  cla_slice_add #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .s     (slice_sum_s),
    .cout  (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  assign last_s = (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered, so they are derived from the next state.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      ST_IDLE: in_ready_d  = 1'b1;
      ST_RUN:  in_ready_d  = 1'b0;
      ST_DONE: out_valid_d = 1'b1;
      default: in_ready_d  = 1'b0;
    endcase
  end

  // Datapath next values: operand capture, slice stepping, result latch.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q;
        end
      end
      ST_RUN: begin
        // Slice results enter at the top and move down; after NSLICE steps
        // slice k occupies sum[k*SLICE +: SLICE].
        sum_d   = {slice_sum_s, sum_q[WIDTH-1:SLICE]};
        a_d     = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
        b_d     = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
        carry_d = slice_cout_s;
        if (last_s) begin
          cout_d = slice_cout_s;
          ovf_d  = slice_cout_s ^ slice_cmsb_s;
          idx_d  = idx_q;
        end else begin
          idx_d  = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        idx_d = idx_q;
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

`ifdef CLA_WIDE_ADD_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  // Count completed result handshakes; wraps naturally at 16 bits.
  always_comb begin
    if (out_valid_q && out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_wide_add_seq
// Self-checking bench for cla_wide_add_seq at default parameters
// (WIDTH = 64, SLICE = 16). Expected results come from plain 64-bit
// arithmetic. Define CLA_WIDE_ADD_STATS_EN to also check op_count.
// ---------------------------------------------------------------------------
module tb_cla_wide_add_seq;

  localparam int W   = 64;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
`ifdef CLA_WIDE_ADD_STATS_EN
  logic [15:0]  op_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  cla_wide_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
`ifdef CLA_WIDE_ADD_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  // Absolute safety net in case a wait is ever unbounded.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry_out, sum} from plain arithmetic.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [64:0] wide;
    logic [63:0] r;
    logic        c;
    logic        v;
    if (!s) begin
      wide = {1'b0, a} + {1'b0, b};
      r    = wide[63:0];
      c    = wide[64];
      v    = (a[63] == b[63]) && (r[63] != a[63]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[63] != b[63]) && (r[63] != a[63]);
    end
    return {v, c, r};
  endfunction

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic hold_ready);
    logic [65:0] e;
    int          lat;
    e = model(a, b, s);
    out_ready = hold_ready;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, ".lat"}, 64'(lat), 64'(LAT));
    check({tag, ".sum"}, sum, e[63:0]);
    check({tag, ".cout"}, 64'(carry_out), 64'(e[64]));
    check({tag, ".ovf"}, 64'(overflow), 64'(e[65]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check({tag, ".drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".drain_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [65:0] e;
    int          lat;
    int          bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.sum", sum, 64'd0);
    check("rst.cout", 64'(carry_out), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op("borrow", 64'd0, 64'd1, 1'b1, 1'b0);
    run_op("sub5_3", 64'd5, 64'd3, 1'b1, 1'b0);
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);

    // Backpressure: result held, new operands ignored.
    e = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
    start_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
    wait_done(lat);
    check("bp.lat", 64'(lat), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        op_a = 64'hDEAD; op_b = 64'hBEEF; sub = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.sum", sum, e[63:0]);
      check("bp.cout", 64'(carry_out), 64'(e[64]));
      check("bp.ovf", 64'(overflow), 64'(e[65]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check("bp.drain_valid", 64'(out_valid), 64'd0);
    check("bp.drain_ready", 64'(in_ready), 64'd1);
    // The ignored pulse must not have started a new operation.
    repeat (6) @(negedge clk);
    check("bp.no_ghost", 64'(out_valid), 64'd0);

    // Reset two cycles after accept aborts the operation.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("abort.valid", 64'(out_valid), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.sum", sum, 64'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("abort.never_valid", 64'(bad), 64'd0);
    run_op("post_abort", 64'h1234, 64'h1, 1'b0, 1'b0);

    // Randomized operations, alternating consumer behaviour.
    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 0) rb = ~ra;
      if (i % 5 == 0) ra = {1'b0, ra[62:0]};
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'(i % 2));
    end

`ifdef CLA_WIDE_ADD_STATS_EN
    check("stats.count", 64'(op_count), 64'(exp_cnt));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    start_op(64'd9, 64'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op("stats_op", 64'(i), 64'd7, 1'b0, 1'b0);
    end
    check("stats.three", 64'(op_count), 64'd3);
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    run_op("stats_wrap", 64'd1, 64'd2, 1'b0, 1'b0);
    check("stats.wrap", 64'(op_count), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
